param_shift_engine: RTL and testbench
=====================================

// Module: param_shift_engine
// PURPOSE
//  Parametrised successor to the fixed 30-bit pipe shift register.
//  - Holds a WIDTH-bit pattern that scrolls pipe/obstacle columns across the screen.
//  - Adds a built-in step prescaler, four shift modes (shift-left, rotate, shift-right, LFSR)
//    and parallel load.
//  - Adds a per-step strobe and a full-pass wrap flag; sits between the game tick generator and the pipe renderer.
// PARAMETERS
//  WIDTH     30              register length in bits (>=2)
//  SHIFT_DIV 1               enabled cycles per shift step (>=1)
//  TAPS      30'h20000029    LFSR feedback mask, bit i set => reg[i] XORed into feedback (WIDTH bits)
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  resetn       in   1      reset, synchronous, active-low
//  en           in   1      advance prescaler this cycle
//  mode         in   2      00 shl, 01 rotl, 10 shr, 11 lfsr; sampled at step edge
//  data_in      in   1      serial input for modes 00/10
//  load         in   1      parallel load strobe
//  load_data    in   WIDTH  value loaded when load=1
//  par_out      out  WIDTH  current register contents (registered)
//  bit_out      out  1      bit pushed out by the last step (registered)
//  shift_pulse  out  1      one-cycle strobe, high in the cycle after a step edge
//  wrap         out  1      one-cycle strobe with shift_pulse when step WIDTH of a pass completes
// BEHAVIOUR
//  Reset: clk is the only clock; reset is resetn, synchronous, active-low.
//   - resetn=0 at posedge => par_out=0, bit_out=0, shift_pulse=0, wrap=0, div_cnt=0, step_cnt=0.
//   - Reset overrides load and en.
//  Priority: reset > load > step.
//  Load (load=1):
//   - par_out<=load_data, bit_out<=0, div_cnt<=0, step_cnt<=0, shift_pulse<=0, wrap<=0.
//   - Takes effect regardless of en; no step on that edge.
//  Prescaler:
//   - en=1, load=0: if div_cnt==SHIFT_DIV-1 then div_cnt<=0 and a step occurs on this edge,
//     else div_cnt<=div_cnt+1.
//   - en=0: div_cnt holds, no step.
//   - SHIFT_DIV=1: every enabled cycle is a step.
//  Step, per mode (R = pre-edge par_out):
//   - 00: par_out<={R[W-2:0],data_in}, bit_out<=R[W-1]
//   - 01: par_out<={R[W-2:0],R[W-1]}, bit_out<=R[W-1]
//   - 10: par_out<={data_in,R[W-1:1]}, bit_out<=R[0]
//   - 11: fb = ^(R & TAPS); if R==0 then fb=1 (lockup escape);
//         par_out<={R[W-2:0],fb}, bit_out<=R[W-1]
//  Outputs on non-step edges:
//   - par_out and bit_out hold on every non-step, non-load edge.
//  Step counter (width $clog2(WIDTH)):
//   - Increments each step; at WIDTH-1 it wraps to 0 and wrap<=1.
//   - shift_pulse<=1 on every step edge.
//   - Both strobes return to 0 on the next edge unless another step occurs (back-to-back steps keep shift_pulse high).
//  Mode change:
//   - Between steps: no effect until the next step edge.
//   - Mid-pass: does not clear step_cnt or div_cnt.
//  Mid-operation:
//   - Reset or load mid-prescale discards the partial count.
//   - en and load in the same cycle => load wins, prescaler cleared.
//  Latency: data_in reaches par_out[0] (mode 00) on the step edge itself; visible the cycle after.
// TESTING
//  1. Reset: W=30,DIV=1; resetn=0 one edge with load=1,en=1 -> par_out=0, bit_out=0, strobes 0.
//  2. Shift-left: W=8, load 8'hA5, mode 00, data_in=1, en=1 x3 steps
//     -> par_out 4B,97,2F; bit_out 1,0,1; shift_pulse high 3 cycles.
//  3. Rotate + wrap: W=8, load 8'h81, mode 01, en=1 x8 -> par_out back to 81;
//     wrap high only after 8th step; step_cnt=0.
//  4. Prescale: W=8, DIV=3, load 01, mode 00, data_in=0, en=1 x9 -> 3 steps at edges 3,6,9;
//     par_out=08; en=0 gaps hold div_cnt.
//  5. LFSR lockup: W=8, TAPS=8'hB8, load 00, mode 11, 1 step -> par_out=01;
//     next step -> 02 (fb=0); no stall at zero.
//  6. Collisions: load=1 with en=1 at div boundary -> load_data wins, no shift_pulse;
//     shift-right W=8 from 80 with data_in=1 -> C0, bit_out=0.

Source files
------------

// File: rtl/param_shift_engine.sv
// Parametrised pipe/obstacle scroll register with step prescaler, four shift modes,
// parallel load, per-step strobe and full-pass wrap flag.
module param_shift_engine #(
  parameter int unsigned         WIDTH     = 30,
  parameter int unsigned         SHIFT_DIV = 1,
  parameter logic [WIDTH-1:0]    TAPS      = WIDTH'(30'h20000029)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             data_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] par_out,
  output logic             bit_out,
  output logic             shift_pulse,
  output logic             wrap
);

  localparam int unsigned DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_SHL  = 2'b00,
    MODE_ROTL = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LFSR = 2'b11
  } mode_e;

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  logic [WIDTH-1:0] par_q, par_d;
  logic             bit_q, bit_d;
  logic             shift_pulse_q, shift_pulse_d;
  logic             wrap_q, wrap_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

  logic step;
  logic fb;

  // An all-zero register would otherwise lock the LFSR; force a 1 in.
  assign fb = (par_q == '0) ? 1'b1 : ^(par_q & TAPS);

  always_comb begin
    par_d         = par_q;
    bit_d         = bit_q;
    div_cnt_d     = div_cnt_q;
    step_cnt_d    = step_cnt_q;
    shift_pulse_d = 1'b0;
    wrap_d        = 1'b0;
    step          = 1'b0;

    if (load) begin
      par_d      = load_data;
      bit_d      = 1'b0;
      div_cnt_d  = '0;
      step_cnt_d = '0;
    end else if (en) begin
      if (div_cnt_q == DIV_W'(SHIFT_DIV - 1)) begin
        div_cnt_d = '0;
        step      = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end

    if (step) begin
      shift_pulse_d = 1'b1;
      case (mode_sel)
        MODE_SHL: begin
          par_d = {par_q[WIDTH-2:0], data_in};
          bit_d = par_q[WIDTH-1];
        end
        MODE_ROTL: begin
          par_d = {par_q[WIDTH-2:0], par_q[WIDTH-1]};
          bit_d = par_q[WIDTH-1];
        end
        MODE_SHR: begin
          par_d = {data_in, par_q[WIDTH-1:1]};
          bit_d = par_q[0];
        end
        default: begin
          par_d = {par_q[WIDTH-2:0], fb};
          bit_d = par_q[WIDTH-1];
        end
      endcase
      if (step_cnt_q == CNT_W'(WIDTH - 1)) begin
        step_cnt_d = '0;
        wrap_d     = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      par_q         <= '0;
      bit_q         <= 1'b0;
      shift_pulse_q <= 1'b0;
      wrap_q        <= 1'b0;
      div_cnt_q     <= '0;
      step_cnt_q    <= '0;
    end else begin
      par_q         <= par_d;
      bit_q         <= bit_d;
      shift_pulse_q <= shift_pulse_d;
      wrap_q        <= wrap_d;
      div_cnt_q     <= div_cnt_d;
      step_cnt_q    <= step_cnt_d;
    end
  end

  assign par_out     = par_q;
  assign bit_out     = bit_q;
  assign shift_pulse = shift_pulse_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_param_shift_engine.sv
// Directed bench for param_shift_engine: three instances (W30/DIV1, W8/DIV1, W8/DIV3).
module tb_param_shift_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic        a_en, a_load, a_din;
  logic [1:0]  a_mode;
  logic [29:0] a_load_data, a_par;
  logic        a_bit, a_sp, a_wrap;

  logic        b_en, b_load, b_din;
  logic [1:0]  b_mode;
  logic [7:0]  b_load_data, b_par;
  logic        b_bit, b_sp, b_wrap;

  logic        c_en, c_load, c_din;
  logic [1:0]  c_mode;
  logic [7:0]  c_load_data, c_par;
  logic        c_bit, c_sp, c_wrap;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  param_shift_engine #(.WIDTH(30), .SHIFT_DIV(1)) u_a (
    .clk(clk), .resetn(resetn), .en(a_en), .mode(a_mode), .data_in(a_din),
    .load(a_load), .load_data(a_load_data), .par_out(a_par), .bit_out(a_bit),
    .shift_pulse(a_sp), .wrap(a_wrap)
  );

  param_shift_engine #(.WIDTH(8), .SHIFT_DIV(1), .TAPS(8'hB8)) u_b (
    .clk(clk), .resetn(resetn), .en(b_en), .mode(b_mode), .data_in(b_din),
    .load(b_load), .load_data(b_load_data), .par_out(b_par), .bit_out(b_bit),
    .shift_pulse(b_sp), .wrap(b_wrap)
  );

  param_shift_engine #(.WIDTH(8), .SHIFT_DIV(3), .TAPS(8'hB8)) u_c (
    .clk(clk), .resetn(resetn), .en(c_en), .mode(c_mode), .data_in(c_din),
    .load(c_load), .load_data(c_load_data), .par_out(c_par), .bit_out(c_bit),
    .shift_pulse(c_sp), .wrap(c_wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] rot_exp [8];

  initial begin
    rot_exp = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

    a_en = 1'b1; a_load = 1'b1; a_din = 1'b0; a_mode = 2'b00; a_load_data = 30'h3FFFFFFF;
    b_en = 1'b1; b_load = 1'b1; b_din = 1'b0; b_mode = 2'b00; b_load_data = 8'hFF;
    c_en = 1'b0; c_load = 1'b0; c_din = 1'b0; c_mode = 2'b00; c_load_data = 8'h00;
    resetn = 1'b0;

    // reset overrides load and en
    tick();
    check("a_reset_par", 32'(a_par), 32'h0);
    check("a_reset_bit", 32'(a_bit), 32'h0);
    check("a_reset_sp", 32'(a_sp), 32'h0);
    check("a_reset_wrap", 32'(a_wrap), 32'h0);
    check("b_reset_par", 32'(b_par), 32'h0);
    check("c_reset_par", 32'(c_par), 32'h0);
    resetn = 1'b1;
    a_load = 1'b0; a_en = 1'b0;
    b_load = 1'b0; b_en = 1'b0;

    // shift-left
    b_load = 1'b1; b_load_data = 8'hA5;
    tick();
    check("shl_load", 32'(b_par), 32'hA5);
    check("shl_load_sp", 32'(b_sp), 32'h0);
    b_load = 1'b0; b_mode = 2'b00; b_din = 1'b1; b_en = 1'b1;
    tick();
    check("shl_1_par", 32'(b_par), 32'h4B);
    check("shl_1_bit", 32'(b_bit), 32'h1);
    check("shl_1_sp", 32'(b_sp), 32'h1);
    tick();
    check("shl_2_par", 32'(b_par), 32'h97);
    check("shl_2_bit", 32'(b_bit), 32'h0);
    check("shl_2_sp", 32'(b_sp), 32'h1);
    tick();
    check("shl_3_par", 32'(b_par), 32'h2F);
    check("shl_3_bit", 32'(b_bit), 32'h1);
    check("shl_3_sp", 32'(b_sp), 32'h1);
    b_en = 1'b0;
    tick();
    check("shl_hold_par", 32'(b_par), 32'h2F);
    check("shl_hold_sp", 32'(b_sp), 32'h0);

    // rotate with wrap on the 8th step
    b_load = 1'b1; b_load_data = 8'h81; b_mode = 2'b01;
    tick();
    b_load = 1'b0; b_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rot_%0d_par", i + 1), 32'(b_par), 32'(rot_exp[i]));
      check($sformatf("rot_%0d_wrap", i + 1), 32'(b_wrap), (i == 7) ? 32'h1 : 32'h0);
    end
    // second pass: step counter restarted from zero
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rot2_%0d_wrap", i + 1), 32'(b_wrap), (i == 7) ? 32'h1 : 32'h0);
    end
    b_en = 1'b0;
    tick();
    check("rot_wrap_clear", 32'(b_wrap), 32'h0);
    check("rot_sp_clear", 32'(b_sp), 32'h0);

    // LFSR lockup escape and feedback
    b_load = 1'b1; b_load_data = 8'h00; b_mode = 2'b11;
    tick();
    b_load = 1'b0; b_en = 1'b1;
    tick();
    check("lfsr_escape", 32'(b_par), 32'h01);
    tick();
    check("lfsr_fb0", 32'(b_par), 32'h02);
    check("lfsr_fb0_bit", 32'(b_bit), 32'h0);
    b_load = 1'b1; b_load_data = 8'h98;
    tick();
    check("lfsr_load_wins", 32'(b_par), 32'h98);
    check("lfsr_load_sp", 32'(b_sp), 32'h0);
    b_load = 1'b0;
    tick();
    check("lfsr_fb1", 32'(b_par), 32'h31);
    check("lfsr_fb1_bit", 32'(b_bit), 32'h1);
    b_en = 1'b0;

    // shift-right
    b_load = 1'b1; b_load_data = 8'h80; b_mode = 2'b10; b_din = 1'b1;
    tick();
    b_load = 1'b0; b_en = 1'b1;
    tick();
    check("shr_par", 32'(b_par), 32'hC0);
    check("shr_bit", 32'(b_bit), 32'h0);
    b_en = 1'b0;

    // prescaler with en gaps
    c_load = 1'b1; c_load_data = 8'h01;
    tick();
    c_load = 1'b0; c_mode = 2'b00; c_din = 1'b0; c_en = 1'b1;
    tick();
    check("div_e1_sp", 32'(c_sp), 32'h0);
    tick();
    check("div_e2_sp", 32'(c_sp), 32'h0);
    c_en = 1'b0;
    tick();
    tick();
    check("div_gap_sp", 32'(c_sp), 32'h0);
    check("div_gap_par", 32'(c_par), 32'h01);
    c_en = 1'b1;
    tick();
    check("div_e3_sp", 32'(c_sp), 32'h1);
    check("div_e3_par", 32'(c_par), 32'h02);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("div_e%0d_sp", i + 4), 32'(c_sp), (i == 2 || i == 5) ? 32'h1 : 32'h0);
    end
    check("div_final_par", 32'(c_par), 32'h08);

    // load at the prescaler boundary discards the partial count
    tick();
    tick();
    c_load = 1'b1; c_load_data = 8'h5A;
    tick();
    check("coll_par", 32'(c_par), 32'h5A);
    check("coll_sp", 32'(c_sp), 32'h0);
    check("coll_bit", 32'(c_bit), 32'h0);
    c_load = 1'b0;
    tick();
    check("coll_p1_sp", 32'(c_sp), 32'h0);
    tick();
    check("coll_p2_sp", 32'(c_sp), 32'h0);
    tick();
    check("coll_p3_sp", 32'(c_sp), 32'h1);
    check("coll_p3_par", 32'(c_par), 32'hB4);

    // reset mid-operation
    b_en = 1'b1; b_mode = 2'b00; b_din = 1'b1;
    tick();
    resetn = 1'b0;
    tick();
    check("midrst_par", 32'(b_par), 32'h0);
    check("midrst_sp", 32'(b_sp), 32'h0);
    check("midrst_bit", 32'(b_bit), 32'h0);
    resetn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
